// File: rtl/wb_scoreboard_pkg.sv
// Shared scoreboard types: slot/warp/register identifiers and the slot record
// used by the writeback scoreboard.
package gDefine;

  localparam int SCOREBOARD_SIZE = 32;
  localparam int WARP_COUNT      = 32;
  localparam int VREG_IDX_BITS   = 6;

  typedef logic [$clog2(SCOREBOARD_SIZE)-1:0] RsvID_t;
  typedef logic [$clog2(WARP_COUNT)-1:0]      WarpID_t;
  typedef logic [VREG_IDX_BITS-1:0]           VRegIdx_t;

  // Slot record at the default geometry; warp/vreg are don't-care while valid=0.
  typedef struct packed {
    logic     valid;
    WarpID_t  warp;
    VRegIdx_t vreg;
  } SbSlot_t;

endpackage

// File: rtl/sb_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module sb_prio_enc #(
  parameter  int W  = 32,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Walk downward so the lowest set bit is the last (winning) assignment.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: reserves destination registers per warp, flags RAW/WAW
// hazards on several check ports, and frees slots on writeback or warp flush.
module wb_scoreboard
  import gDefine::*;
#(
  parameter  int ENTRIES   = SCOREBOARD_SIZE,
  parameter  int NUM_WARPS = WARP_COUNT,
  parameter  int REG_BITS  = VREG_IDX_BITS,
  parameter  int CHK_PORTS = 3,
  localparam int WW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int IW        = $clog2(ENTRIES)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alloc_valid,
  input  logic [WW-1:0]                      alloc_warp,
  input  logic [REG_BITS-1:0]                alloc_reg,
  output logic                               alloc_ready,
  output logic [IW-1:0]                      alloc_id,
  input  logic                               rel_valid,
  input  logic [IW-1:0]                      rel_id,
  input  logic                               flush_valid,
  input  logic [WW-1:0]                      flush_warp,
  input  logic [WW-1:0]                      chk_warp,
  input  logic [CHK_PORTS-1:0][REG_BITS-1:0] chk_reg,
  output logic [CHK_PORTS-1:0]               chk_busy,
  output logic [IW:0]                        count,
  output logic                               full,
  output logic                               empty,
  output logic                               rel_err
);

  typedef struct packed {
    logic                valid;
    logic [WW-1:0]       warp;
    logic [REG_BITS-1:0] vreg;
  } slot_t;

  slot_t               slots [ENTRIES];
  logic [ENTRIES-1:0]  vld, allocHit, flushHit, relHit, setHit, vldNext;
  logic                freeFound, allocFire, flushKillsAlloc, relErrNext;
  logic [IW:0]         cntNext;

  for (genvar i = 0; i < ENTRIES; i++) begin : gVld
    assign vld[i] = slots[i].valid;
  end

  sb_prio_enc #(.W(ENTRIES)) uFreeEnc (
    .req   (~vld),
    .idx   (alloc_id),
    .found (freeFound)
  );

  assign full  = (count == (IW + 1)'(ENTRIES));
  assign empty = (count == '0);

  // A flush of the requesting warp would orphan the new reservation, so stall it.
  assign flushKillsAlloc = flush_valid && (flush_warp == alloc_warp);
  assign alloc_ready     = !full && freeFound && !(|allocHit) && !flushKillsAlloc;
  assign allocFire       = alloc_valid && alloc_ready;
  assign relErrNext      = rel_valid && !vld[rel_id];

  always_comb begin
    allocHit = '0;
    flushHit = '0;
    relHit   = '0;
    setHit   = '0;
    vldNext  = '0;
    cntNext  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      allocHit[i] = vld[i] && (slots[i].warp == alloc_warp) && (slots[i].vreg == alloc_reg);
      flushHit[i] = vld[i] && flush_valid && (slots[i].warp == flush_warp);
      relHit[i]   = rel_valid && (rel_id == IW'(i));
      setHit[i]   = allocFire && (alloc_id == IW'(i));
      vldNext[i]  = setHit[i] || (vld[i] && !relHit[i] && !flushHit[i]);
      cntNext     = cntNext + (IW + 1)'(vldNext[i]);
    end
  end

  // Hazard checks see only committed state; same-cycle alloc/release is not bypassed.
  for (genvar p = 0; p < CHK_PORTS; p++) begin : gChk
    logic [ENTRIES-1:0] hit;
    always_comb begin
      hit = '0;
      for (int i = 0; i < ENTRIES; i++)
        hit[i] = vld[i] && (slots[i].warp == chk_warp) && (slots[i].vreg == chk_reg[p]);
    end
    assign chk_busy[p] = |hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) slots[i].valid <= 1'b0;
      count   <= '0;
      rel_err <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        slots[i].valid <= vldNext[i];
        if (setHit[i]) begin
          slots[i].warp <= alloc_warp;
          slots[i].vreg <= alloc_reg;
        end
      end
      count   <= cntNext;
      rel_err <= relErrNext;
    end
  end

endmodule
